// File: rtl/updown_bcd_display.sv
// Multi-decade reversible BCD counter with prescaled count tick and a
// time-multiplexed, leading-zero-blanked 7-segment display driver.
module updown_bcd_display #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ud,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   value,
    output logic [7:0]            an,
    output logic [7:0]            sgm,
    output logic                  rco
);

    localparam int VW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0] pre, pre_nxt;
    logic [SW-1:0] sc, sc_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [VW-1:0] value_nxt;
    logic [VW:0]   inc_res, dec_res;
    logic [7:0]    an_nxt, sgm_nxt;
    logic [3:0]    digit_nxt;
    logic          rco_nxt, tick, scan_tc;

    function automatic logic [VW-1:0] bcd_clamp(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Result carries the wrap flag in its MSB.
    function automatic logic [VW:0] bcd_inc(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    function automatic logic [VW:0] bcd_dec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return {b, r};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // A digit is a leading zero when it and every more significant digit are 0.
    function automatic logic blank_digit(input logic [VW-1:0] v, input int k);
        logic b;
        b = (k != 0);
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= k && v[4*i +: 4] != 4'd0) b = 1'b0;
        end
        return b;
    endfunction

    always_comb begin
        tick      = en && (pre == PW'(TICK_DIV - 1));
        inc_res   = bcd_inc(value);
        dec_res   = bcd_dec(value);
        value_nxt = value;
        pre_nxt   = pre;
        rco_nxt   = 1'b0;
        if (load) begin
            value_nxt = bcd_clamp(load_val);
            pre_nxt   = '0;
        end else if (tick) begin
            pre_nxt = '0;
            if (ud) begin
                value_nxt = inc_res[VW-1:0];
                rco_nxt   = inc_res[VW];
            end else begin
                value_nxt = dec_res[VW-1:0];
                rco_nxt   = dec_res[VW];
            end
        end else if (en) begin
            pre_nxt = pre + PW'(1);
        end
    end

    always_comb begin
        scan_tc = (sc == SW'(SCAN_DIV - 1));
        sc_nxt  = scan_tc ? '0 : sc + SW'(1);
        idx_nxt = idx;
        if (scan_tc) idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end

    // Anode and segments are both derived from next-state idx and value so the
    // registered pair always describes the same digit with its current content.
    always_comb begin
        an_nxt    = 8'hFF;
        digit_nxt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (i < DIGITS && IW'(i) == idx_nxt) an_nxt[i] = 1'b0;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_nxt) digit_nxt = value_nxt[4*i +: 4];
        end
        if (BLANK_LZ != 0 && blank_digit(value_nxt, int'(idx_nxt)))
            sgm_nxt = 8'hFF;
        else
            sgm_nxt = {1'b1, seg7(digit_nxt)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
            pre   <= '0;
            rco   <= 1'b0;
            sc    <= '0;
            idx   <= '0;
            an    <= 8'hFE;
            sgm   <= 8'hC0;
        end else begin
            value <= value_nxt;
            pre   <= pre_nxt;
            rco   <= rco_nxt;
            sc    <= sc_nxt;
            idx   <= idx_nxt;
            an    <= an_nxt;
            sgm   <= sgm_nxt;
        end
    end

endmodule

// File: tb/tb_updown_bcd_display.sv
// Bench for updown_bcd_display: decimal-arithmetic reference model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_updown_bcd_display;

    localparam int TD = 4;
    localparam int SD = 3;

    logic        clk, rst, ud, en, load;
    logic [15:0] load_val;
    logic [15:0] value0, value1;
    logic [7:0]  an0, an1, sgm0, sgm1;
    logic        rco0, rco1;
    bit          chk;
    int          errors, checks;

    int m_val, m_pre, m_sc, m_idx;
    bit m_rco;

    updown_bcd_display #(.DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1)) dut0 (
        .clk(clk), .rst(rst), .ud(ud), .en(en), .load(load), .load_val(load_val),
        .value(value0), .an(an0), .sgm(sgm0), .rco(rco0));

    updown_bcd_display #(.DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(0)) dut1 (
        .clk(clk), .rst(rst), .ud(ud), .en(en), .load(load), .load_val(load_val),
        .value(value1), .an(an1), .sgm(sgm1), .rco(rco1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int clamp_val(input logic [15:0] v);
        int s;
        int d;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            s = s + d * pow10(i);
        end
        return s;
    endfunction

    function automatic logic [15:0] to_bcd(input int val);
        logic [15:0] r;
        int v;
        v = val;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  default: return 7'h10;
        endcase
    endfunction

    function automatic logic [7:0] exp_sgm(input int val, input int idx, input bit blank);
        int p;
        p = pow10(idx);
        if (blank && idx > 0 && val < p) return 8'hFF;
        return {1'b1, seg_of((val / p) % 10)};
    endfunction

    function automatic logic [7:0] exp_an(input int idx);
        logic [7:0] t;
        t = 8'hFF;
        t[idx] = 1'b0;
        return t;
    endfunction

    // Reference model: count kept as a plain integer 0..9999.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_val <= 0; m_pre <= 0; m_sc <= 0; m_idx <= 0; m_rco <= 1'b0;
        end else begin
            if (load) begin
                m_val <= clamp_val(load_val);
                m_pre <= 0;
                m_rco <= 1'b0;
            end else if (en && m_pre == TD - 1) begin
                m_pre <= 0;
                if (ud) begin
                    m_val <= (m_val + 1) % 10000;
                    m_rco <= (m_val == 9999);
                end else begin
                    m_val <= (m_val == 0) ? 9999 : m_val - 1;
                    m_rco <= (m_val == 0);
                end
            end else begin
                if (en) m_pre <= m_pre + 1;
                m_rco <= 1'b0;
            end
            if (m_sc == SD - 1) begin
                m_sc  <= 0;
                m_idx <= (m_idx + 1) % 4;
            end else begin
                m_sc <= m_sc + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("model value0", value0, to_bcd(m_val));
            check("model rco0", rco0, m_rco);
            check("model an0", an0, exp_an(m_idx));
            check("model sgm0", sgm0, exp_sgm(m_val, m_idx, 1'b1));
            check("model value1", value1, to_bcd(m_val));
            check("model rco1", rco1, m_rco);
            check("model an1", an1, exp_an(m_idx));
            check("model sgm1", sgm1, exp_sgm(m_val, m_idx, 1'b0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    logic [7:0] t5_an [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    logic [7:0] t5_s0 [4] = '{8'hA4, 8'h99, 8'hFF, 8'hFF};
    logic [7:0] t5_s1 [4] = '{8'hA4, 8'h99, 8'hC0, 8'hC0};

    initial begin
        errors = 0; checks = 0; chk = 0;
        rst = 1'b1; ud = 1'b1; en = 1'b0; load = 1'b0; load_val = 16'h0000;
        #1 rst = 1'b0;
        #1 chk = 1;
        check("reset value", value0, 16'h0000);
        check("reset an", an0, 8'hFE);
        check("reset sgm", sgm0, 8'hC0);
        check("reset rco", rco0, 1'b0);
        check("reset sgm nblank", sgm1, 8'hC0);

        // T1: up count from 0, one step every TD clocks
        repeat (3) @(posedge clk);
        #2 rst = 1'b1; en = 1'b1; ud = 1'b1;
        cyc(35);
        check("t1 value@35", value0, 16'h0008);
        cyc(1);
        check("t1 value@36", value0, 16'h0009);
        cyc(4);
        check("t1 value@40", value0, 16'h0010);
        check("t1 rco", rco0, 1'b0);

        // T2: wrap up and down
        load = 1'b1; load_val = 16'h9999;
        cyc(1);
        load = 1'b0;
        check("t2 load", value0, 16'h9999);
        cyc(3);
        check("t2 pre-wrap value", value0, 16'h9999);
        check("t2 pre-wrap rco", rco0, 1'b0);
        cyc(1);
        check("t2 wrap up value", value0, 16'h0000);
        check("t2 wrap up rco", rco0, 1'b1);
        ud = 1'b0;
        cyc(1);
        check("t2 rco one cycle", rco0, 1'b0);
        cyc(3);
        check("t2 wrap down value", value0, 16'h9999);
        check("t2 wrap down rco", rco0, 1'b1);

        // T3: clamped load, then load coinciding with a tick
        load = 1'b1; load_val = 16'hA5F3;
        cyc(1);
        load = 1'b0;
        check("t3 clamp", value0, 16'h9593);
        cyc(3);
        load = 1'b1; load_val = 16'h1234;
        cyc(1);
        load = 1'b0;
        check("t3 load beats tick", value0, 16'h1234);
        check("t3 load rco", rco0, 1'b0);

        // T4: hold mid-count
        ud = 1'b1;
        cyc(2);
        en = 1'b0;
        cyc(10);
        check("t4 frozen", value0, 16'h1234);
        en = 1'b1;
        cyc(1);
        check("t4 resume pre", value0, 16'h1234);
        cyc(1);
        check("t4 resume tick", value0, 16'h1235);

        // T5: scan sequence and blanking on 0042
        en = 1'b0; load = 1'b1; load_val = 16'h0042;
        cyc(1);
        load = 1'b0;
        check("t5 load", value0, 16'h0042);
        for (int i = 0; i < 20 && an0 == 8'hFE; i++) cyc(1);
        for (int i = 0; i < 20 && an0 != 8'hFE; i++) cyc(1);
        for (int k = 0; k < 4; k++) begin
            check("t5 an0", an0, t5_an[k]);
            check("t5 sgm0", sgm0, t5_s0[k]);
            check("t5 an1", an1, t5_an[k]);
            check("t5 sgm1", sgm1, t5_s1[k]);
            cyc(3);
        end

        // T6: asynchronous reset while rco is high and mid-scan
        ud = 1'b1; en = 1'b1; load = 1'b1; load_val = 16'h9999;
        cyc(1);
        load = 1'b0;
        cyc(4);
        check("t6 rco before rst", rco0, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t6 async value", value0, 16'h0000);
        check("t6 async rco", rco0, 1'b0);
        check("t6 async an", an0, 8'hFE);
        check("t6 async sgm", sgm0, 8'hC0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        cyc(3);
        check("t6 restart hold", value0, 16'h0000);
        cyc(1);
        check("t6 restart step", value0, 16'h0001);
        cyc(5);
        #2 rst = 1'b0;
        #1;
        check("t6 midcount value", value0, 16'h0000);
        check("t6 midcount an", an0, 8'hFE);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        cyc(4);
        check("t6 second restart", value0, 16'h0001);

        chk = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
